// File: rtl/euler_seq_multiplier_if.sv
// Request/response bundle for the Euler-step shift-add multiplier.
// master: issues start with operands a/b; slave: the multiplier itself.
interface euler_seq_multiplier_if #(
   parameter int Size = 8
);
   logic            start;
   logic [Size-1:0] a;
   logic [Size-1:0] b;
   logic            busy;
   logic            done_mul;
   logic [Size-1:0] p;

   modport master (output start, a, b, input busy, done_mul, p);
   modport slave  (input start, a, b, output busy, done_mul, p);
endinterface

// File: rtl/euler_seq_multiplier.sv
// Sequential shift-add signed fixed-point multiplier (h*f) for the Euler step.
// Computes on magnitudes, reapplies the sign at the end, then rescales by FRAC
// with floor semantics. One result every Size+2 cycles.
// Optional build macro MUL_SAT_EN: saturate the rescaled product to Size bits
// instead of wrapping.
module euler_seq_multiplier #(
   parameter int Size = 8,
   parameter int FRAC = 4
) (
   input  logic                  clk,
   input  logic                  rst_sync,
   euler_seq_multiplier_if.slave bus
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_MUL  = 2'd1;
   localparam logic [1:0] ST_FIN  = 2'd2;

   localparam int            CW   = $clog2(Size);
   localparam logic [CW-1:0] LAST = CW'(Size - 1);

   logic [1:0]          state;
   logic [Size-1:0]     mcand;
   logic [Size-1:0]     mplier;
   logic                sign;
   logic [2*Size-1:0]   acc;
   logic [CW-1:0]       cnt;
   logic [Size-1:0]     p_q;
   logic                done_q;

   logic [Size-1:0]     a_mag;
   logic [Size-1:0]     b_mag;
   logic [2*Size-1:0]   partial;
   logic signed [2*Size:0] acc_ext;
   logic signed [2*Size:0] sprod;
   logic signed [2*Size:0] r;
   logic [Size-1:0]     p_next;

   // Operand magnitudes; the most negative value maps to 2^(Size-1), which
   // still fits as an unsigned Size-bit number.
   always_comb begin
      a_mag = bus.a[Size-1] ? (~bus.a + 1'b1) : bus.a;
      b_mag = bus.b[Size-1] ? (~bus.b + 1'b1) : bus.b;
   end

   // Shifted multiplicand for the current iteration plus sign restore and
   // floor rescale of the finished product.
   always_comb begin
      partial = {{Size{1'b0}}, mcand} << cnt;
      acc_ext = {1'b0, acc};
      sprod   = sign ? -acc_ext : acc_ext;
      r       = sprod >>> FRAC;
   end

`ifdef MUL_SAT_EN
   localparam logic signed [2*Size:0] PMAX = {{(Size+2){1'b0}}, {(Size-1){1'b1}}};
   localparam logic signed [2*Size:0] PMIN = {{(Size+2){1'b1}}, {(Size-1){1'b0}}};

   // Clamp out-of-range results to the representable extremes.
   always_comb begin
      if (r > PMAX)
         p_next = {1'b0, {(Size-1){1'b1}}};
      else if (r < PMIN)
         p_next = {1'b1, {(Size-1){1'b0}}};
      else
         p_next = r[Size-1:0];
   end
`else
   logic unused_r_hi;

   // Plain truncation: high bits of the rescaled product are dropped.
   always_comb begin
      p_next      = r[Size-1:0];
      unused_r_hi = ^r[2*Size:Size];
   end
`endif

   // Control FSM and datapath; reset discards any in-flight product.
   always_ff @(posedge clk) begin
      if (!rst_sync) begin
         state  <= ST_IDLE;
         mcand  <= '0;
         mplier <= '0;
         sign   <= 1'b0;
         acc    <= '0;
         cnt    <= '0;
         p_q    <= '0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.start) begin
                  mcand  <= a_mag;
                  mplier <= b_mag;
                  sign   <= bus.a[Size-1] ^ bus.b[Size-1];
                  acc    <= '0;
                  cnt    <= '0;
                  state  <= ST_MUL;
               end
            end
            ST_MUL: begin
               if (mplier[0])
                  acc <= acc + partial;
               mplier <= mplier >> 1;
               cnt    <= cnt + 1'b1;
               if (cnt == LAST)
                  state <= ST_FIN;
            end
            ST_FIN: begin
               p_q    <= p_next;
               done_q <= 1'b1;
               state  <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy     = (state == ST_MUL) || (state == ST_FIN);
   assign bus.done_mul = done_q;
   assign bus.p        = p_q;
endmodule

// File: tb/tb_euler_seq_multiplier.sv
// Scoreboard bench for euler_seq_multiplier: driver pushes expected results
// (value and arrival cycle), a negedge monitor (the buffer's view) pops them.
module tb_euler_seq_multiplier;
   localparam int SIZE = 8;
   localparam int FRAC = 4;
   localparam int LAT  = SIZE + 2;

   typedef struct {
      logic [SIZE-1:0] p;
      int              cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_sync;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic rst_at_edge = 1'b1;
   logic [SIZE-1:0] model_p = '0;
   exp_t sbq[$];

   euler_seq_multiplier_if #(.Size(SIZE)) bus ();

   euler_seq_multiplier #(.Size(SIZE), .FRAC(FRAC)) dut (
      .clk     (clk),
      .rst_sync(rst_sync),
      .bus     (bus.slave)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rst_at_edge = ~rst_sync;

   function automatic void chk(string name, longint act, longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Reference: true signed product, floor-divided by 2^FRAC, then fitted.
   function automatic logic [SIZE-1:0] model(logic [SIZE-1:0] x, logic [SIZE-1:0] y);
      longint prod, res;
      prod = longint'($signed(x)) * longint'($signed(y));
      res  = prod >>> FRAC;
`ifdef MUL_SAT_EN
      if (res > (longint'(1) << (SIZE-1)) - 1) res = (longint'(1) << (SIZE-1)) - 1;
      if (res < -(longint'(1) << (SIZE-1)))    res = -(longint'(1) << (SIZE-1));
`endif
      return res[SIZE-1:0];
   endfunction

   // Buffer-side monitor: samples on the falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (rst_at_edge) begin
         chk("rst_busy", bus.busy, 0);
         chk("rst_done", bus.done_mul, 0);
         chk("rst_p", bus.p, 0);
         model_p = '0;
      end else if (bus.done_mul) begin
         if (sbq.size() == 0) begin
            chk("unexpected_done", 1, 0);
         end else begin
            e = sbq.pop_front();
            chk("p_value", bus.p, e.p);
            chk("done_cycle", cyc, e.cyc);
            model_p = e.p;
         end
      end else begin
         chk("p_hold", bus.p, model_p);
         if (sbq.size() > 0 && cyc > sbq[0].cyc) begin
            chk("missing_done", 0, 1);
            void'(sbq.pop_front());
         end
      end
   end

   task automatic issue(logic [SIZE-1:0] x, logic [SIZE-1:0] y);
      exp_t e;
      bus.start = 1'b1;
      bus.a     = x;
      bus.b     = y;
      e.p   = model(x, y);
      e.cyc = cyc + LAT;
      sbq.push_back(e);
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = SIZE'($urandom);
      bus.b     = SIZE'($urandom);
   endtask

   // One operation; optionally measure how long busy stays high.
   task automatic run_op(logic [SIZE-1:0] x, logic [SIZE-1:0] y, bit chk_busy);
      int n;
      issue(x, y);
      n = 0;
      while (bus.busy && n < 4 * LAT) begin
         n++;
         @(negedge clk);
      end
      if (chk_busy) chk("busy_len", n, SIZE + 1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      logic [SIZE-1:0] ha, hb;
      int t0;
      rst_sync  = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      repeat (2) @(negedge clk);
      rst_sync = 1'b1;
      @(negedge clk);

      // Directed vectors.
      run_op(8'h18, 8'h20, 1'b1);
      run_op(8'hE8, 8'h20, 1'b1);
      run_op(8'hFF, 8'h08, 1'b0);
      run_op(8'h40, 8'h40, 1'b0);
      run_op(8'h80, 8'h80, 1'b1);
      run_op(8'h00, 8'h7F, 1'b1);
      run_op(8'h7F, 8'h80, 1'b0);

      // Reset on the 4th MUL cycle: nothing may come out.
      bus.start = 1'b1;
      bus.a     = 8'h18;
      bus.b     = 8'h20;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      rst_sync = 1'b0;
      @(negedge clk);
      rst_sync = 1'b1;
      repeat (LAT + 2) @(negedge clk);
      run_op(8'h18, 8'h20, 1'b1);

      // A second start during MUL must be ignored.
      issue(8'h30, 8'hD8);
      repeat (2) @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 8'h55;
      bus.b     = 8'h33;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (LAT + 4) @(negedge clk);

      // start held high: back-to-back results every Size+2 cycles.
      ha = SIZE'($urandom);
      hb = SIZE'($urandom);
      t0 = cyc;
      bus.start = 1'b1;
      bus.a     = ha;
      bus.b     = hb;
      for (int i = 0; i < 4; i++) begin
         exp_t e;
         e.p   = model(ha, hb);
         e.cyc = t0 + LAT + i * LAT;
         sbq.push_back(e);
      end
      while (cyc < t0 + 4 * LAT && cyc < t0 + 100) @(negedge clk);
      bus.start = 1'b0;
      repeat (LAT + 2) @(negedge clk);

      // Randomised operands.
      for (int i = 0; i < 40; i++)
         run_op(SIZE'($urandom), SIZE'($urandom), i < 4);

      repeat (LAT + 2) @(negedge clk);
      chk("scoreboard_empty", sbq.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
